// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver and its FIFO.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10,
    RSVD = 2'b11
  } parity_mode_e;

  typedef logic [2:0] rx_state_e;
  localparam rx_state_e IDLE       = 3'd0;
  localparam rx_state_e START      = 3'd1;
  localparam rx_state_e DATA       = 3'd2;
  localparam rx_state_e PARITY     = 3'd3;
  localparam rx_state_e STOP       = 3'd4;
  localparam rx_state_e BREAK_WAIT = 3'd5;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  typedef logic [2:0] rx_err_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy and sticky overflow.
module uart_rx_fifo #(
  parameter int WIDTH      = 11,
  parameter int FIFO_WIDTH = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  input  logic                  clr_ovf_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  ovf_o,
  output logic [FIFO_WIDTH:0]   count_o
);
  localparam int ENTRIES = 2**FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] ENTRIES_C = ENTRIES;
  localparam logic [FIFO_WIDTH:0] HALF_C    = ENTRIES / 2;

  logic [WIDTH-1:0]      mem_q [ENTRIES];
  logic [FIFO_WIDTH-1:0] wr_q, rd_q;
  logic [FIFO_WIDTH:0]   cnt_q, cnt_d;
  logic                  full_q, ovf_q, ovf_d;
  logic                  do_push, do_pop, drop;

  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && ((cnt_q != ENTRIES_C) || do_pop);
  assign drop    = push_i && !do_push;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    ovf_d = drop ? 1'b1 : (clr_ovf_i ? 1'b0 : ovf_q);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d > HALF_C);
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  assign full_o  = full_q;
  assign ovf_o   = ovf_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: majority-voted bit sampling, runtime parity, break detect,
// frames queued with their error flags in a FWFT FIFO that also drives RTS.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_WIDTH = 4,
  parameter int LSB_FIRST  = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Baud_Tick,
  input  logic                  Rx,
  input  logic [1:0]            Parity_Mode,
  input  logic                  Pop_Data,
  output logic [DATA_BITS-1:0]  Data_Out,
  output logic [2:0]            Rx_Error,
  output logic                  Data_Rdy,
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full,
  output logic                  FIFO_Overflow,
  input  logic                  Clear_Overflow,
  output logic                  RTS,
  output logic                  Rx_Busy,
  output logic [FIFO_WIDTH:0]   Count
);
  localparam int MID = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int W   = DATA_BITS + 3;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [1:0]           samp_q, samp_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, shifted;
  parity_mode_e         pmode_q, pmode_d;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                 zero_q, zero_d, brk_q, brk_d;
  logic                 push_q, push_d;
  logic [W-1:0]         pdata_q, pdata_d, head;
  logic                 vote, decide, brk_now, frm_now;
  rx_err_t              err;

  assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
  assign decide = Baud_Tick && (tick_q == TW'(MID + 1));

  always_comb begin
    if (LSB_FIRST != 0) shifted = {vote, shreg_q[DATA_BITS-1:1]};
    else                shifted = {shreg_q[DATA_BITS-2:0], vote};
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    samp_d    = samp_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    pmode_d   = pmode_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    zero_d    = zero_q;
    brk_d     = brk_q;
    push_d    = 1'b0;
    pdata_d   = pdata_q;
    err       = '0;
    brk_now   = brk_q;
    frm_now   = frm_err_q;
    if (Baud_Tick) begin
      tick_d = (tick_q == TW'(OVERSAMPLE - 1)) ? '0 : tick_q + 1'b1;
      if (tick_q == TW'(MID - 1)) samp_d[0] = rx_s2_q;
      if (tick_q == TW'(MID))     samp_d[1] = rx_s2_q;
    end
    case (state_q)
      IDLE: if (rx_prev_q && !rx_s2_q) begin
        state_d = START;
        tick_d  = '0;
        pmode_d = parity_mode_e'(Parity_Mode);
      end
      START: if (decide) begin
        if (vote) state_d = IDLE;
        else begin
          state_d   = DATA;
          bcnt_d    = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          brk_d     = 1'b0;
        end
      end
      DATA: if (decide) begin
        shreg_d = shifted;
        if (bcnt_q == 4'(DATA_BITS - 1)) begin
          bcnt_d  = '0;
          zero_d  = (shifted == '0);
          state_d = (pmode_q == EVEN || pmode_q == ODD) ? PARITY : STOP;
        end else bcnt_d = bcnt_q + 1'b1;
      end
      PARITY: if (decide) begin
        par_err_d = ((^shreg_q) ^ vote) != (pmode_q == ODD);
        zero_d    = zero_q & ~vote;
        state_d   = STOP;
      end
      STOP: if (decide) begin
        // Break is decided on the first stop bit, the push waits for the last one.
        brk_now   = (bcnt_q == '0) ? (zero_q & ~vote) : brk_q;
        frm_now   = frm_err_q | ~vote;
        brk_d     = brk_now;
        frm_err_d = frm_now;
        if (bcnt_q == 4'(STOP_BITS - 1)) begin
          err[ERR_BREAK]  = brk_now;
          err[ERR_PARITY] = par_err_q & ~brk_now;
          err[ERR_FRAME]  = frm_now & ~brk_now;
          push_d  = 1'b1;
          pdata_d = {err, brk_now ? {DATA_BITS{1'b0}} : shreg_q};
          if (brk_now) begin
            state_d = BREAK_WAIT;
            tick_d  = '0;
          end else state_d = IDLE;
        end else bcnt_d = bcnt_q + 1'b1;
      end
      BREAK_WAIT: begin
        // Line must stay high for a whole bit period before a new start is accepted.
        if (!rx_s2_q) tick_d = '0;
        else if (Baud_Tick && tick_q == TW'(OVERSAMPLE - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      tick_q    <= '0;
      samp_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      pmode_q   <= NONE;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      zero_q    <= 1'b0;
      brk_q     <= 1'b0;
      push_q    <= 1'b0;
      pdata_q   <= '0;
    end else begin
      rx_s1_q   <= Rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      samp_q    <= samp_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      pmode_q   <= pmode_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      zero_q    <= zero_d;
      brk_q     <= brk_d;
      push_q    <= push_d;
      pdata_q   <= pdata_d;
    end
  end

  uart_rx_fifo #(.WIDTH(W), .FIFO_WIDTH(FIFO_WIDTH)) u_fifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .push_i   (push_q),
    .din_i    (pdata_q),
    .pop_i    (Pop_Data),
    .clr_ovf_i(Clear_Overflow),
    .dout_o   (head),
    .empty_o  (FIFO_Empty),
    .full_o   (FIFO_Full),
    .ovf_o    (FIFO_Overflow),
    .count_o  (Count)
  );

  assign Data_Out = head[DATA_BITS-1:0];
  assign Rx_Error = head[W-1:DATA_BITS];
  assign Data_Rdy = !FIFO_Empty;
  assign RTS      = !FIFO_Full;
  assign Rx_Busy  = (state_q != IDLE);

endmodule
